bbcore_seq: RTL and testbench
=============================

Name: bbcore_seq

Overview:
- Parametrised successor of the fixed 16-tile BitBlade core.
- Instantiates N_ACT_GRP x N_WGT_GRP pe_array_64 tiles and adds a sequencing controller.
- The controller accepts a burst of LEN act/weight beats over a valid/ready handshake and drives bias-select, accumulate and flush automatically.
- It captures all tile psums on completion and drains them over a narrower valid/ready output stream. It sits between the act/weight buffers and the psum writeback unit.

Parameters:
- N_ACT_GRP, 4, activation groups; tile i uses act group i % N_ACT_GRP.
- N_WGT_GRP, 4, weight groups; tile i uses weight group i / N_ACT_GRP.
- N_TILE, N_ACT_GRP*N_WGT_GRP, tile count (derived; do not override).
- OUT_LANES, 4, psums per output beat; must divide N_TILE.
- LEN_W, 8, width of the burst-length field.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset; also drives every tile's RST.
- i_Start  in  1  start a job; sampled only in IDLE.
- i_Len  in  LEN_W  number of accumulation beats; latched at start.
- i_Precision  in  2  activation precision; latched at start.
- w_Precision  in  2  weight precision; latched at start.
- i_Use_Bias  in  1  load bias on first beat; latched at start.
- i_Bias  in  N_BIAS*N_TILE  per-tile bias; latched at start.
- i_Vld  in  1  act/weight beat valid.
- o_Rdy  out  1  controller ready for an act/weight beat.
- i_Act  in  BITS_ACT*PE_ROW*N_ACT_GRP  activation beat.
- i_Weight  in  BITS_WEIGHT*PE_ROW*N_WGT_GRP  weight beat.
- o_Vld  out  1  psum beat valid.
- i_Rdy  in  1  downstream ready.
- o_Psum  out  BITS_PSUM*OUT_LANES  psum beat; lane k = tile (beat*OUT_LANES + k).
- o_Last  out  1  final psum beat of the job.
- o_Busy  out  1  high in any state other than IDLE.
- o_Err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: state = IDLE; o_Rdy, o_Vld, o_Last, o_Busy, o_Err = 0; o_Psum = 0; counters and latched config = 0.
- IDLE:
  - i_Start with i_Len != 0: latch config -> ACCUM next cycle.
  - i_Start with i_Len == 0: o_Err = 1 for one cycle; stay in IDLE.
- ACCUM:
  - o_Rdy = 1. A beat is accepted when i_Vld & o_Rdy.
  - Each accepted beat is registered and presented to every tile the following cycle with core_vld = 1. Fixed 1-cycle input latency.
  - Tile sideband on the registered beat: Sel_Bias = latched i_Use_Bias on the first beat only; Flush = 1 on beat LEN only; tile precision = {i_Precision, w_Precision}.
  - i_Vld low: core_vld = 0 that cycle and no count.
  - After beat LEN is accepted: o_Rdy drops in the same cycle (combinational on count) -> WAIT_DONE.
- WAIT_DONE:
  - o_Rdy = 0.
  - Wait until every tile's o_Done is high (AND-reduce). Tiles that assert Done early hold until all are high.
  - On that cycle, capture all N_TILE psums into the drain buffer -> DRAIN.
- DRAIN:
  - Beats 0 .. N_TILE/OUT_LANES-1, in order. o_Vld = 1 with o_Psum = buffer slice for the current beat index.
  - Beat advances only on o_Vld & i_Rdy. o_Psum stays stable while i_Rdy = 0.
  - o_Last = 1 on the final beat. When that beat is accepted -> IDLE next cycle, o_Vld = 0.
- Jobs do not overlap. i_Start outside IDLE is ignored: no error, no config change.
- Reset asserted in any state: all state returns to IDLE next edge. In-flight beats and buffered psums are discarded and no further o_Vld occurs.
- Simultaneous i_Vld during IDLE (before the job starts): not accepted, since o_Rdy = 0.
- Counters: beat counter is LEN_W bits with no wrap (max LEN = 2^LEN_W - 1). Drain index is clog2(N_TILE/OUT_LANES) bits, minimum 1.

Decomposition:
- BITS_ACT, BITS_WEIGHT, BITS_PSUM, N_BIAS and PE_ROW stay in the shared parameters.v include.
- FSM state encodings (IDLE = 0, ACCUM = 1, WAIT_DONE = 2, DRAIN = 3) are added there as localparam-style defines.
- Sub-module bb_psum_drain: capture buffer plus valid/ready serializer with o_Last generation.
- Tiles are generated pe_array_64 instances, as in the existing core.

Test Plan:
- All acts/weights = 0, i_Use_Bias = 1, bias = 5 per tile, LEN = 3, i_Rdy = 1 -> 4 beats of four psums each equal to 5. o_Last on beat 3; o_Busy low one cycle after.
- LEN = 4 with i_Vld toggling 1,0,1,0,... -> exactly 4 core_vld pulses; Flush only with the 4th; o_Rdy low from the acceptance of beat 4.
- Random acts/weights, precision {2,2}, LEN = 8 -> psums match the pe_array_64 golden model per tile, in lane order tile 0..15.
- Drain with i_Rdy pattern 0,0,1,0,1,1,0,1 -> each o_Psum beat held stable while stalled; no beat dropped or duplicated.
- i_Start with i_Len = 0 -> o_Err one-cycle pulse, o_Busy stays 0; i_Start during ACCUM -> ignored, job completes unchanged.
- RST asserted mid-DRAIN (after beat 1) -> next cycle o_Vld = 0, o_Busy = 0; a following job with bias = 7 yields all psums = 7.

Source files
------------

// File: rtl/bbcore_seq_pkg.sv
// Shared widths, FSM states and operand masking for the BitBlade sequencer.
// No ports; imported by the tiles, the drain serializer and the top.
package bbcore_seq_pkg;

  localparam int BITS_ACT    = 8;
  localparam int BITS_WEIGHT = 8;
  localparam int BITS_PSUM   = 24;
  localparam int N_BIAS      = 8;
  localparam int PE_ROW      = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCUM     = 2'd1,
    WAIT_DONE = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  // Precision code p keeps the low (2 << p) operand bits, capped at 8.
  function automatic logic [7:0] prec_mask(input logic [1:0] p);
    logic [7:0] m;
    case (p)
      2'd0:    m = 8'h03;
      2'd1:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bb_psum_drain.sv
// Captures all tile psums and serializes them OUT_LANES at a time.
// Ports: CLK/RST, capture strobe, flat psum vector, valid/ready psum beat, last flag.
module bb_psum_drain
  import bbcore_seq_pkg::*;
#(
  parameter int N_TILE    = 16,
  parameter int OUT_LANES = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           i_Capture,
  input  logic [BITS_PSUM*N_TILE-1:0]    i_Psum_All,
  output logic                           o_Vld,
  input  logic                           i_Rdy,
  output logic [BITS_PSUM*OUT_LANES-1:0] o_Psum,
  output logic                           o_Last
);

  localparam int N_BEAT = N_TILE / OUT_LANES;
  localparam int IDX_W  = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
  localparam int BEAT_W = BITS_PSUM * OUT_LANES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEAT - 1);

  logic [BITS_PSUM*N_TILE-1:0] psum_buf;
  logic [IDX_W-1:0]            idx;
  logic                        vld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      psum_buf <= '0;
      idx      <= '0;
      vld      <= 1'b0;
    end else if (i_Capture) begin
      psum_buf <= i_Psum_All;
      idx      <= '0;
      vld      <= 1'b1;
    end else if (vld && i_Rdy) begin
      if (idx == LAST_IDX)
        vld <= 1'b0;
      else
        idx <= idx + IDX_W'(1);
    end
  end

  assign o_Vld  = vld;
  assign o_Last = vld && (idx == LAST_IDX);
  assign o_Psum = psum_buf[int'(idx)*BEAT_W +: BEAT_W];

endmodule

// File: rtl/pe_array_64.sv
// One BitBlade tile: PE_ROW masked act*weight products accumulated per beat.
// Ports: CLK/RST, beat valid, precision, bias select/value, flush, act, weight, psum, done.
module pe_array_64
  import bbcore_seq_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_Vld,
  input  logic [3:0]                i_Precision,
  input  logic                      i_Sel_Bias,
  input  logic                      i_Flush,
  input  logic [N_BIAS-1:0]         i_Bias,
  input  logic [BITS_ACT*PE_ROW-1:0]    i_Act,
  input  logic [BITS_WEIGHT*PE_ROW-1:0] i_Weight,
  output logic [BITS_PSUM-1:0]      o_Psum,
  output logic                      o_Done
);

  logic [7:0]           am;
  logic [7:0]           wm;
  logic [15:0]          prod;
  logic [BITS_PSUM-1:0] dot;
  logic [BITS_PSUM-1:0] base;
  logic [BITS_PSUM-1:0] acc;
  logic                 done;

  always_comb begin
    am   = prec_mask(i_Precision[3:2]);
    wm   = prec_mask(i_Precision[1:0]);
    dot  = '0;
    prod = '0;
    for (int j = 0; j < PE_ROW; j++) begin
      prod = 16'(i_Act[j*BITS_ACT +: BITS_ACT] & am)
           * 16'(i_Weight[j*BITS_WEIGHT +: BITS_WEIGHT] & wm);
      dot  = dot + BITS_PSUM'(prod);
    end
    // A finished result is dropped when the next job's first beat arrives.
    if (i_Sel_Bias)
      base = BITS_PSUM'(i_Bias);
    else if (done)
      base = '0;
    else
      base = acc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc  <= '0;
      done <= 1'b0;
    end else if (i_Vld) begin
      acc  <= base + dot;
      done <= i_Flush;
    end
  end

  assign o_Psum = acc;
  assign o_Done = done;

endmodule

// File: rtl/bbcore_seq.sv
// Sequenced BitBlade core: burst act/weight intake, tile array, psum drain.
// Ports: job config + start/err/busy, act/weight valid/ready in, psum valid/ready out.
module bbcore_seq
  import bbcore_seq_pkg::*;
#(
  parameter int N_ACT_GRP = 4,
  parameter int N_WGT_GRP = 4,
  parameter int N_TILE    = N_ACT_GRP * N_WGT_GRP,
  parameter int OUT_LANES = 4,
  parameter int LEN_W     = 8
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                i_Start,
  input  logic [LEN_W-1:0]                    i_Len,
  input  logic [1:0]                          i_Precision,
  input  logic [1:0]                          w_Precision,
  input  logic                                i_Use_Bias,
  input  logic [N_BIAS*N_TILE-1:0]            i_Bias,
  input  logic                                i_Vld,
  output logic                                o_Rdy,
  input  logic [BITS_ACT*PE_ROW*N_ACT_GRP-1:0]    i_Act,
  input  logic [BITS_WEIGHT*PE_ROW*N_WGT_GRP-1:0] i_Weight,
  output logic                                o_Vld,
  input  logic                                i_Rdy,
  output logic [BITS_PSUM*OUT_LANES-1:0]      o_Psum,
  output logic                                o_Last,
  output logic                                o_Busy,
  output logic                                o_Err
);

  localparam int ACT_W = BITS_ACT * PE_ROW;
  localparam int WGT_W = BITS_WEIGHT * PE_ROW;

  state_t                       state;
  state_t                       state_nxt;
  logic [LEN_W-1:0]             cnt;
  logic [LEN_W-1:0]             len;
  logic [3:0]                   prec;
  logic                         use_bias;
  logic [N_BIAS*N_TILE-1:0]     bias;
  logic                         err;
  logic                         core_vld;
  logic                         sel_bias;
  logic                         flush;
  logic [ACT_W*N_ACT_GRP-1:0]   act_r;
  logic [WGT_W*N_WGT_GRP-1:0]   wgt_r;
  logic [N_TILE-1:0]            done;
  logic [BITS_PSUM*N_TILE-1:0]  psum_all;
  logic                         rdy;
  logic                         accept;
  logic                         last_beat;
  logic                         go;
  logic                         bad_start;
  logic                         capture;

  assign rdy       = (state == ACCUM) && (cnt != len);
  assign accept    = i_Vld && rdy;
  assign last_beat = (cnt + LEN_W'(1)) == len;
  assign go        = (state == IDLE) && i_Start && (i_Len != '0);
  assign bad_start = (state == IDLE) && i_Start && (i_Len == '0);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE:
        if (go) state_nxt = ACCUM;
      ACCUM:
        if (accept && last_beat) state_nxt = WAIT_DONE;
      // Wait for the flush beat to reach the tiles so a stale Done
      // left over from the previous job is never mistaken for ours.
      WAIT_DONE:
        if (!core_vld && (&done)) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end
      DRAIN:
        if (o_Vld && i_Rdy && o_Last) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      prec     <= '0;
      use_bias <= 1'b0;
      bias     <= '0;
      err      <= 1'b0;
      core_vld <= 1'b0;
      sel_bias <= 1'b0;
      flush    <= 1'b0;
      act_r    <= '0;
      wgt_r    <= '0;
    end else begin
      state    <= state_nxt;
      err      <= bad_start;
      core_vld <= accept;
      if (go) begin
        len      <= i_Len;
        prec     <= {i_Precision, w_Precision};
        use_bias <= i_Use_Bias;
        bias     <= i_Bias;
        cnt      <= '0;
      end
      if (accept) begin
        act_r    <= i_Act;
        wgt_r    <= i_Weight;
        sel_bias <= use_bias && (cnt == '0);
        flush    <= last_beat;
        cnt      <= cnt + LEN_W'(1);
      end else begin
        sel_bias <= 1'b0;
        flush    <= 1'b0;
      end
    end
  end

  for (genvar t = 0; t < N_TILE; t++) begin : g_tile
    localparam int AG = t % N_ACT_GRP;
    localparam int WG = t / N_ACT_GRP;
    pe_array_64 u_pe (
      .CLK        (CLK),
      .RST        (RST),
      .i_Vld      (core_vld),
      .i_Precision(prec),
      .i_Sel_Bias (sel_bias),
      .i_Flush    (flush),
      .i_Bias     (bias[t*N_BIAS +: N_BIAS]),
      .i_Act      (act_r[AG*ACT_W +: ACT_W]),
      .i_Weight   (wgt_r[WG*WGT_W +: WGT_W]),
      .o_Psum     (psum_all[t*BITS_PSUM +: BITS_PSUM]),
      .o_Done     (done[t])
    );
  end

  bb_psum_drain #(
    .N_TILE   (N_TILE),
    .OUT_LANES(OUT_LANES)
  ) u_drain (
    .CLK       (CLK),
    .RST       (RST),
    .i_Capture (capture),
    .i_Psum_All(psum_all),
    .o_Vld     (o_Vld),
    .i_Rdy     (i_Rdy),
    .o_Psum    (o_Psum),
    .o_Last    (o_Last)
  );

  assign o_Rdy  = rdy;
  assign o_Busy = (state != IDLE);
  assign o_Err  = err;

endmodule

// File: tb/tb_bbcore_seq.sv
// Self-checking bench for bbcore_seq against a per-tile dot-product model.
// Drives jobs with random data, valid and ready patterns; checks every psum beat.
module tb_bbcore_seq;

  localparam int NA = 4;
  localparam int NT = 16;
  localparam int OL = 4;
  localparam int NB = NT / OL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [7:0]   len;
  logic [1:0]   ap;
  logic [1:0]   wp;
  logic         ub;
  logic [127:0] bias;
  logic         vld;
  logic         ordy;
  logic [127:0] act;
  logic [127:0] wgt;
  logic         ovld;
  logic         rdy;
  logic [95:0]  psum;
  logic         olast;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_ps [NT];
  logic [1:0]  job_ap;
  logic [1:0]  job_wp;
  logic [95:0] got_beats [$];
  logic        got_last [$];
  int          accepted;

  bbcore_seq dut (
    .CLK        (clk),
    .RST        (rst),
    .i_Start    (start),
    .i_Len      (len),
    .i_Precision(ap),
    .w_Precision(wp),
    .i_Use_Bias (ub),
    .i_Bias     (bias),
    .i_Vld      (vld),
    .o_Rdy      (ordy),
    .i_Act      (act),
    .i_Weight   (wgt),
    .o_Vld      (ovld),
    .i_Rdy      (rdy),
    .o_Psum     (psum),
    .o_Last     (olast),
    .o_Busy     (busy),
    .o_Err      (err)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int unsigned opmask(input logic [1:0] p);
    if (p == 2'd0) return 3;
    if (p == 2'd1) return 15;
    return 255;
  endfunction

  task automatic model_start(input logic u, input logic [127:0] b);
    for (int t = 0; t < NT; t++)
      exp_ps[t] = u ? 24'(b[t*8 +: 8]) : 24'd0;
  endtask

  // Tile t sees act group t%NA and weight group t/NA, four 8-bit lanes each.
  task automatic model_beat(input logic [127:0] a, input logic [127:0] w);
    int unsigned am, wm, s, x, y;
    am = opmask(job_ap);
    wm = opmask(job_wp);
    for (int t = 0; t < NT; t++) begin
      s = 0;
      for (int j = 0; j < 4; j++) begin
        x = a[((t % NA) * 4 + j) * 8 +: 8];
        y = w[((t / NA) * 4 + j) * 8 +: 8];
        s = s + (x & am) * (y & wm);
      end
      exp_ps[t] = exp_ps[t] + 24'(s);
    end
  endtask

  function automatic logic [95:0] exp_beat(input int b);
    logic [95:0] r;
    for (int k = 0; k < OL; k++)
      r[k*24 +: 24] = exp_ps[b*OL + k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l, input logic [1:0] a,
                           input logic [1:0] w, input logic u,
                           input logic [127:0] b);
    len    = 8'(l);
    ap     = a;
    wp     = w;
    ub     = u;
    bias   = b;
    job_ap = a;
    job_wp = w;
    model_start(u, b);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    len    = 8'($urandom);
    ap     = 2'($urandom);
    wp     = 2'($urandom);
    ub     = 1'($urandom);
    bias   = rnd128();
  endtask

  // mode 0: always valid, 1: alternate 1,0,..., 2: random.
  task automatic send_beats(input int n, input int mode, input logic zero);
    accepted = 0;
    for (int c = 0; c < 2000 && accepted < n; c++) begin
      if (mode == 0)      vld = 1'b1;
      else if (mode == 1) vld = ((c % 2) == 0);
      else                vld = 1'($urandom_range(0, 1));
      act = zero ? '0 : rnd128();
      wgt = zero ? '0 : rnd128();
      if (vld && ordy) begin
        model_beat(act, wgt);
        accepted++;
      end
      tick();
    end
    vld = 1'b0;
  endtask

  // mode 0: always ready, otherwise random ready.
  task automatic collect(input int mode);
    got_beats.delete();
    got_last.delete();
    for (int c = 0; c < 400 && got_beats.size() < NB; c++) begin
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ovld && rdy) begin
        got_beats.push_back(psum);
        got_last.push_back(olast);
      end
      tick();
    end
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vld = 1'b0; rdy = 1'b0;
    len = '0; ap = '0; wp = '0; ub = 1'b0;
    bias = '0; act = '0; wgt = '0;
    tick();
    tick();
    checks++;
    if ({ordy, ovld, olast, busy, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/last/busy/err=%b, expected 00000",
               {ordy, ovld, olast, busy, err});
    end
    checks++;
    if (psum !== 96'd0) begin
      errors++;
      $display("FAIL reset_psum: got %h, expected 0", psum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bias_only();
    start_job(3, 2'd0, 2'd0, 1'b1, {16{8'd5}});
    send_beats(3, 0, 1'b1);
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (b >= got_beats.size()) begin
        errors++;
        $display("FAIL bias_beat%0d: missing, expected %h", b, {4{24'd5}});
      end else if (got_beats[b] !== {4{24'd5}} || got_last[b] !== (b == NB-1)) begin
        errors++;
        $display("FAIL bias_beat%0d: got %h last %b, expected %h last %b",
                 b, got_beats[b], got_last[b], {4{24'd5}}, (b == NB-1));
      end
    end
    checks++;
    if (busy !== 1'b0 || ovld !== 1'b0) begin
      errors++;
      $display("FAIL bias_end: got busy %b vld %b, expected 0 0", busy, ovld);
    end
  endtask

  task automatic test_vld_toggle();
    start_job(4, 2'($urandom), 2'($urandom), 1'($urandom), rnd128());
    send_beats(4, 1, 1'b0);
    checks++;
    if (accepted !== 4 || ordy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_accept: got %0d beats rdy %b, expected 4 rdy 0",
               accepted, ordy);
    end
    for (int c = 0; c < 2; c++) begin
      vld = 1'b1;
      act = rnd128();
      wgt = rnd128();
      checks++;
      if (ordy !== 1'b0) begin
        errors++;
        $display("FAIL toggle_rdy_low%0d: got %b, expected 0", c, ordy);
      end
      tick();
    end
    vld = 1'b0;
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (b >= got_beats.size() || got_beats[b] !== exp_beat(b)) begin
        errors++;
        $display("FAIL toggle_beat%0d: got %h, expected %h", b,
                 (b < got_beats.size()) ? got_beats[b] : 96'hx, exp_beat(b));
      end
    end
  endtask

  task automatic test_random();
    int l, vm, rm;
    logic [1:0] a, w;
    for (int j = 0; j < 6; j++) begin
      if (j == 0) begin
        l = 8; a = 2'd2; w = 2'd2; vm = 0; rm = 0;
      end else begin
        l  = (j == 1) ? 1 : $urandom_range(1, 12);
        a  = 2'($urandom);
        w  = 2'($urandom);
        vm = (j % 2 == 0) ? 2 : 0;
        rm = (j % 3 == 0) ? 0 : 2;
      end
      start_job(l, a, w, 1'($urandom), rnd128());
      send_beats(l, vm, 1'b0);
      collect(rm);
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (b >= got_beats.size()) begin
          errors++;
          $display("FAIL rand_job%0d_beat%0d: missing, expected %h", j, b, exp_beat(b));
        end else if (got_beats[b] !== exp_beat(b) || got_last[b] !== (b == NB-1)) begin
          errors++;
          $display("FAIL rand_job%0d_beat%0d: got %h last %b, expected %h last %b",
                   j, b, got_beats[b], got_last[b], exp_beat(b), (b == NB-1));
        end
      end
    end
  endtask

  task automatic test_stall_drain();
    int          pat [8] = '{0, 0, 1, 0, 1, 1, 0, 1};
    int          vi;
    logic        stalled;
    logic [95:0] held;
    start_job(5, 2'd1, 2'd3, 1'b1, rnd128());
    send_beats(5, 0, 1'b0);
    got_beats.delete();
    got_last.delete();
    vi = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 400 && got_beats.size() < NB; c++) begin
      if (stalled) begin
        checks++;
        if (ovld !== 1'b1 || psum !== held) begin
          errors++;
          $display("FAIL stall_hold: got vld %b psum %h, expected 1 %h", ovld, psum, held);
        end
      end
      if (ovld) begin
        rdy = pat[vi % 8][0];
        vi++;
      end else begin
        rdy = 1'b0;
      end
      stalled = ovld && !rdy;
      held = psum;
      if (ovld && rdy) begin
        got_beats.push_back(psum);
        got_last.push_back(olast);
      end
      tick();
    end
    rdy = 1'b0;
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (b >= got_beats.size() || got_beats[b] !== exp_beat(b)
          || got_last[b] !== (b == NB-1)) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h, expected %h", b,
                 (b < got_beats.size()) ? got_beats[b] : 96'hx, exp_beat(b));
      end
    end
    checks++;
    if (ovld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got vld %b busy %b, expected 0 0", ovld, busy);
    end
  endtask

  task automatic test_err_and_ignore();
    start = 1'b1;
    len = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err %b busy %b, expected 1 0", err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err %b busy %b, expected 0 0", err, busy);
    end
    start_job(5, 2'd2, 2'd1, 1'b1, rnd128());
    start = 1'b1;
    len = 8'd1;
    ub = 1'b0;
    ap = 2'd0;
    bias = rnd128();
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got err %b busy %b, expected 0 1", err, busy);
    end
    send_beats(5, 0, 1'b0);
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (b >= got_beats.size() || got_beats[b] !== exp_beat(b)) begin
        errors++;
        $display("FAIL ignore_beat%0d: got %h, expected %h", b,
                 (b < got_beats.size()) ? got_beats[b] : 96'hx, exp_beat(b));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    start_job(2, 2'd3, 2'd2, 1'b1, rnd128());
    send_beats(2, 0, 1'b0);
    got_beats.delete();
    rdy = 1'b1;
    for (int c = 0; c < 100 && got_beats.size() < 2; c++) begin
      if (ovld) got_beats.push_back(psum);
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (b >= got_beats.size() || got_beats[b] !== exp_beat(b)) begin
        errors++;
        $display("FAIL pre_rst_beat%0d: got %h, expected %h", b,
                 (b < got_beats.size()) ? got_beats[b] : 96'hx, exp_beat(b));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ovld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain: got vld %b busy %b, expected 0 0", ovld, busy);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ovld) seen++;
      tick();
    end
    rdy = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_vld: got %0d valid cycles, expected 0", seen);
    end
    start_job(3, 2'd0, 2'd0, 1'b1, {16{8'd7}});
    send_beats(3, 0, 1'b1);
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (b >= got_beats.size() || got_beats[b] !== {4{24'd7}}) begin
        errors++;
        $display("FAIL post_rst_beat%0d: got %h, expected %h", b,
                 (b < got_beats.size()) ? got_beats[b] : 96'hx, {4{24'd7}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bias_only();
    test_vld_toggle();
    test_random();
    test_stall_drain();
    test_err_and_ignore();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
